btn_input_cond: RTL

BTN_INPUT_COND -- requirements
Module: btn_input_cond

---
 rtl/btn_cond_pkg.sv | 26 ++
 rtl/btn_input_cond_if.sv | 14 +
 rtl/btn_input_cond_sync_2ff.sv | 24 ++
 rtl/btn_input_cond.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and defaults for the button/switch input conditioner.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd16;
  localparam int unsigned DEF_REPEAT_DELAY    = 32'd1000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 32'd250;
  localparam int unsigned SW_W                = 32'd3;

  // Counter width sized by the largest cycle parameter so no count can wrap.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 32'd2) ? 32'd1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_input_cond_if.sv
// Button/switch bundle: raw inputs in, conditioned strobe/level/snapshot out.
interface btn_input_cond_if;
  import btn_cond_pkg::*;

  logic            btn_raw;
  logic [SW_W-1:0] sw_raw;
  logic            btn_pulse;
  logic            btn_level;
  logic [SW_W-1:0] sw_code;
  logic [1:0]      state_dbg;

  modport master (output btn_raw, sw_raw, input btn_pulse, btn_level, sw_code, state_dbg);
  modport slave  (input btn_raw, sw_raw, output btn_pulse, btn_level, sw_code, state_dbg);
endinterface

// File: rtl/btn_input_cond_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, parameterized by width.
module sync_2ff #(
  parameter int unsigned WIDTH = 32'd1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // metastability stage followed by the output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_input_cond.sv
// Debounced button with press strobe and switch snapshot.
// Define BTN_AUTOREPEAT_EN to add auto-repeat pulses while the button is held.
module btn_input_cond
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic              clk,
  input logic              rst,
  btn_input_cond_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic [0:0]      btn_sync;
  logic [SW_W-1:0] sw_sync;
  btn_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic            pulse_nxt, level_nxt;
  logic            btn_pulse, btn_level;
  logic [SW_W-1:0] sw_code;

  sync_2ff #(.WIDTH(32'd1)) u_sync_btn (.clk(clk), .rst(rst), .d(bus.btn_raw), .q(btn_sync));
  sync_2ff #(.WIDTH(SW_W))  u_sync_sw  (.clk(clk), .rst(rst), .d(bus.sw_raw),  .q(sw_sync));

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 32'd1);
  logic [CNT_W-1:0] rep, rep_nxt;
  logic             rep_first, rep_first_nxt;

  // repeat counter and first-repeat-done flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep       <= '0;
      rep_first <= 1'b0;
    end else begin
      rep       <= rep_nxt;
      rep_first <= rep_first_nxt;
    end
  end
`endif

  // next-state, debounce counter and strobe decisions
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    level_nxt = btn_level;
`ifdef BTN_AUTOREPEAT_EN
    rep_nxt       = rep;
    rep_first_nxt = rep_first;
`endif
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (btn_sync[0]) begin
          state_nxt = ST_PRESS_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!btn_sync[0]) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
          level_nxt = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rep_nxt       = '0;
          rep_first_nxt = 1'b0;
`endif
        end else begin
          cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!btn_sync[0]) begin
          state_nxt = ST_RELEASE_WAIT;
          cnt_nxt   = '0;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (rep == (rep_first ? RP_LAST : RD_LAST)) begin
            pulse_nxt     = 1'b1;
            rep_nxt       = '0;
            rep_first_nxt = 1'b1;
          end else begin
            rep_nxt = (rep == CNT_MAX) ? rep : rep + 1'b1;
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      ST_RELEASE_WAIT: begin
        if (btn_sync[0]) begin
          // bounce back to held without a strobe; repeat timing restarts
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
`ifdef BTN_AUTOREPEAT_EN
          rep_nxt       = '0;
          rep_first_nxt = 1'b0;
`endif
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // state and registered outputs; switch snapshot loads only with a strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      btn_pulse <= 1'b0;
      btn_level <= 1'b0;
      sw_code   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_pulse <= pulse_nxt;
      btn_level <= level_nxt;
      if (pulse_nxt) begin
        sw_code <= sw_sync;
      end
    end
  end

  assign bus.btn_pulse = btn_pulse;
  assign bus.btn_level = btn_level;
  assign bus.sw_code   = sw_code;
  assign bus.state_dbg = state;

endmodule
